// File: rtl/rs_issue_ctrl_pkg.sv
// Shared definitions for the Tomasulo issue controller, the reservation
// stations and the CDB arbiter: widths, opcodes, station tags, FSM states
// and the dispatch payload layout.
package rs_issue_ctrl_pkg;

   localparam int DATA_W   = 16;
   localparam int REG_AW   = 3;
   localparam int TAG_W    = 3;
   localparam int NUM_REGS = 1 << REG_AW;
   localparam int NUM_STN  = 4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LD  = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   localparam logic [TAG_W-1:0] FREE_REGISTER      = 3'd0;
   localparam logic [TAG_W-1:0] RES_STATION_ADD1   = 3'd1;
   localparam logic [TAG_W-1:0] RES_STATION_ADD2   = 3'd2;
   localparam logic [TAG_W-1:0] RES_STATION_LOAD1  = 3'd3;
   localparam logic [TAG_W-1:0] RES_STATION_LOAD2  = 3'd4;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_DRAIN   = 2'd1;
   localparam logic [1:0] ST_DRAINED = 2'd2;

   // Operand as seen by a station: a value when tag is FREE_REGISTER,
   // otherwise the tag of the station that will produce it.
   typedef struct packed {
      logic [DATA_W-1:0] val;
      logic [TAG_W-1:0]  tag;
   } operand_t;

   typedef struct packed {
      logic [1:0]        op;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic [TAG_W-1:0]  qj;
      logic [TAG_W-1:0]  qk;
      logic [DATA_W-1:0] a;
   } issue_pkt_t;

   // Only tags naming a real station may retire anything on the CDB.
   function automatic logic isStationTag(input logic [TAG_W-1:0] tag);
      return (tag >= RES_STATION_ADD1) && (tag <= RES_STATION_LOAD2);
   endfunction

endpackage

// File: rtl/rs_issue_ctrl_reg_status_table.sv
// Register file plus register status table (Qi per register). Snoops the
// CDB to retire tags and forwards a same-cycle broadcast onto the two
// operand read ports so a newly issued instruction never misses it.
module rs_issue_ctrl_reg_status_table
   import rs_issue_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] rdAddrJ_i,
   input  logic [REG_AW-1:0] rdAddrK_i,
   output operand_t          opJ_o,
   output operand_t          opK_o,
   input  logic              cdbValid_i,
   input  logic [TAG_W-1:0]  cdbTag_i,
   input  logic [DATA_W-1:0] cdbData_i,
   input  logic              tagWe_i,
   input  logic [REG_AW-1:0] tagWaddr_i,
   input  logic [TAG_W-1:0]  tagWdata_i,
   input  logic              initWe_i,
   input  logic [REG_AW-1:0] initAddr_i,
   input  logic [DATA_W-1:0] initData_i
);

   logic [DATA_W-1:0]   rf_q [NUM_REGS];
   logic [TAG_W-1:0]    qi_q [NUM_REGS];
   logic                cdbActive;
   logic [NUM_REGS-1:0] cdbHit;

   assign cdbActive = cdbValid_i && isStationTag(cdbTag_i);

   // Reads see the pre-update table; a pending tag being broadcast right
   // now is replaced by the broadcast value.
   function automatic operand_t readOperand(input logic [REG_AW-1:0] addr);
      operand_t r;
      r.val = '0;
      r.tag = qi_q[addr];
      if (qi_q[addr] == FREE_REGISTER) begin
         r.val = rf_q[addr];
      end else if (cdbActive && (qi_q[addr] == cdbTag_i)) begin
         r.val = cdbData_i;
         r.tag = FREE_REGISTER;
      end
      return r;
   endfunction

   assign opJ_o = readOperand(rdAddrJ_i);
   assign opK_o = readOperand(rdAddrK_i);

   // Flag every register waiting on the tag currently on the CDB.
   always_comb begin
      cdbHit = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cdbHit[r] = cdbActive && (qi_q[r] == cdbTag_i);
      end
   end

   // CDB write beats preload on the data; a new issue tag beats both on Qi.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            rf_q[r] <= '0;
            qi_q[r] <= FREE_REGISTER;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (cdbHit[r]) begin
               rf_q[r] <= cdbData_i;
            end else if (initWe_i && (initAddr_i == REG_AW'(r))) begin
               rf_q[r] <= initData_i;
            end
            if (tagWe_i && (tagWaddr_i == REG_AW'(r))) begin
               qi_q[r] <= tagWdata_i;
            end else if (cdbHit[r] || (initWe_i && (initAddr_i == REG_AW'(r)))) begin
               qi_q[r] <= FREE_REGISTER;
            end
         end
      end
   end

endmodule

// File: rtl/rs_issue_ctrl.sv
// Tomasulo issue controller: accepts one instruction per cycle, allocates
// a free ADD or LOAD station, and emits a registered one-cycle dispatch
// carrying operand values or producer tags. Also runs the drain FSM.
module rs_issue_ctrl
   import rs_issue_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              instrValid_i,
   output logic              instrReady_o,
   input  logic [1:0]        instrOp_i,
   input  logic [REG_AW-1:0] instrRd_i,
   input  logic [REG_AW-1:0] instrRs_i,
   input  logic [REG_AW-1:0] instrRt_i,
   input  logic [DATA_W-1:0] instrImm_i,
   input  logic              cdbValid_i,
   input  logic [TAG_W-1:0]  qiCdb_i,
   input  logic [DATA_W-1:0] qiCdbData_i,
   input  logic              rfInitWe_i,
   input  logic [REG_AW-1:0] rfInitAddr_i,
   input  logic [DATA_W-1:0] rfInitData_i,
   input  logic              drainReq_i,
   output logic              drained_o,
   output logic              issueAdd1_o,
   output logic              issueAdd2_o,
   output logic              issueLoad1_o,
   output logic              issueLoad2_o,
   output logic [1:0]        issueOp_o,
   output logic [DATA_W-1:0] issueVj_o,
   output logic [DATA_W-1:0] issueVk_o,
   output logic [TAG_W-1:0]  issueQj_o,
   output logic [TAG_W-1:0]  issueQk_o,
   output logic [DATA_W-1:0] issueA_o,
   output logic [NUM_STN-1:0] stnBusy_o
);

   logic [1:0]         state_q, state_d;
   logic [NUM_STN-1:0] stnBusy_q, stnBusy_d;
   logic [NUM_STN-1:0] issueVec_q, issueVec_d;
   issue_pkt_t         issuePkt_q, issuePkt_d;
   logic [TAG_W-1:0]   allocTag;
   logic               isLoad, isAddClass, cdbActive, dispatch, initWeGated;
   operand_t           opJ, opK;

   assign isLoad      = (instrOp_i == OP_LD);
   assign isAddClass  = (instrOp_i == OP_ADD) || (instrOp_i == OP_SUB);
   assign cdbActive   = cdbValid_i && isStationTag(qiCdb_i);
   assign initWeGated = rfInitWe_i && (stnBusy_q == '0);

   // Pick the lowest free station of the class, using only registered busy
   // bits so a station freed by this cycle's CDB waits one cycle.
   always_comb begin
      allocTag = FREE_REGISTER;
      if (isAddClass) begin
         if (!stnBusy_q[0])      allocTag = RES_STATION_ADD1;
         else if (!stnBusy_q[1]) allocTag = RES_STATION_ADD2;
      end else if (isLoad) begin
         if (!stnBusy_q[2])      allocTag = RES_STATION_LOAD1;
         else if (!stnBusy_q[3]) allocTag = RES_STATION_LOAD2;
      end
   end

   assign instrReady_o = (state_q == ST_RUN) && ((instrOp_i == OP_RSV) || (allocTag != FREE_REGISTER));
   assign dispatch     = instrValid_i && instrReady_o && (allocTag != FREE_REGISTER);

   rs_issue_ctrl_reg_status_table u_rst (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rdAddrJ_i  (instrRs_i),
      .rdAddrK_i  (instrRt_i),
      .opJ_o      (opJ),
      .opK_o      (opK),
      .cdbValid_i (cdbValid_i),
      .cdbTag_i   (qiCdb_i),
      .cdbData_i  (qiCdbData_i),
      .tagWe_i    (dispatch),
      .tagWaddr_i (instrRd_i),
      .tagWdata_i (allocTag),
      .initWe_i   (initWeGated),
      .initAddr_i (rfInitAddr_i),
      .initData_i (rfInitData_i)
   );

   // Busy bits: CDB frees its station, a dispatch claims one (never the same).
   always_comb begin
      stnBusy_d = stnBusy_q;
      if (cdbActive) stnBusy_d[qiCdb_i[1:0] - 2'd1] = 1'b0;
      if (dispatch)  stnBusy_d[allocTag[1:0] - 2'd1] = 1'b1;
   end

   // Dispatch payload is zero except on the cycle after an accept.
   always_comb begin
      issueVec_d = '0;
      issuePkt_d = '0;
      if (dispatch) begin
         issueVec_d[allocTag[1:0] - 2'd1] = 1'b1;
         issuePkt_d.op = instrOp_i;
         issuePkt_d.vj = opJ.val;
         issuePkt_d.qj = opJ.tag;
         if (isLoad) begin
            issuePkt_d.a = instrImm_i;
         end else begin
            issuePkt_d.vk = opK.val;
            issuePkt_d.qk = opK.tag;
         end
      end
   end

   // Drain FSM: stop accepting, then report once every station is idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:     if (drainReq_i) state_d = ST_DRAIN;
         ST_DRAIN:   if (!drainReq_i) state_d = ST_RUN;
                     else if (stnBusy_q == '0) state_d = ST_DRAINED;
         ST_DRAINED: if (!drainReq_i) state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   // State registers; reset wins over anything happening in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         stnBusy_q  <= '0;
         issueVec_q <= '0;
         issuePkt_q <= '0;
      end else begin
         state_q    <= state_d;
         stnBusy_q  <= stnBusy_d;
         issueVec_q <= issueVec_d;
         issuePkt_q <= issuePkt_d;
      end
   end

   assign {issueLoad2_o, issueLoad1_o, issueAdd2_o, issueAdd1_o} = issueVec_q;
   assign issueOp_o = issuePkt_q.op;
   assign issueVj_o = issuePkt_q.vj;
   assign issueVk_o = issuePkt_q.vk;
   assign issueQj_o = issuePkt_q.qj;
   assign issueQk_o = issuePkt_q.qk;
   assign issueA_o  = issuePkt_q.a;
   assign stnBusy_o = stnBusy_q;
   assign drained_o = (state_q == ST_DRAINED);

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Testbench for rs_issue_ctrl: a table of directed cycles with hand-derived
// expectations, a reset-during-issue sequence, then randomized traffic
// checked against a register/tag reference model.
module tb_rs_issue_ctrl;

   typedef struct {
      bit          rst;
      bit          valid;
      logic [1:0]  op;
      logic [2:0]  rd, rs, rt;
      logic [15:0] imm;
      bit          cdbV;
      logic [2:0]  tag;
      logic [15:0] cdbD;
      bit          initWe;
      logic [2:0]  initA;
      logic [15:0] initD;
      bit          drain;
      bit          chkRdy;
      bit          expRdy;
      logic [3:0]  expVec;
      logic [1:0]  expOp;
      logic [15:0] expVj, expVk, expA;
      logic [2:0]  expQj, expQk;
      logic [3:0]  expBusy;
      bit          expDrained;
   } vec_t;

   logic        clk;
   logic        rst, instrValid, instrReady, cdbValid, rfInitWe, drainReq, drained;
   logic [1:0]  instrOp, issueOp;
   logic [2:0]  instrRd, instrRs, instrRt, qiCdb, rfInitAddr, issueQj, issueQk;
   logic [15:0] instrImm, qiCdbData, rfInitData, issueVj, issueVk, issueA;
   logic        issueAdd1, issueAdd2, issueLoad1, issueLoad2;
   logic [3:0]  stnBusy;

   int assertCount = 0;
   int failCount   = 0;
   string curTag;

   int mRf[8];
   int mQi[8];
   bit [3:0] mBusy;
   int mMode;

   vec_t tbl[$];

   rs_issue_ctrl dut (
      .clk_i(clk), .rst_i(rst), .instrValid_i(instrValid), .instrReady_o(instrReady),
      .instrOp_i(instrOp), .instrRd_i(instrRd), .instrRs_i(instrRs), .instrRt_i(instrRt),
      .instrImm_i(instrImm), .cdbValid_i(cdbValid), .qiCdb_i(qiCdb), .qiCdbData_i(qiCdbData),
      .rfInitWe_i(rfInitWe), .rfInitAddr_i(rfInitAddr), .rfInitData_i(rfInitData),
      .drainReq_i(drainReq), .drained_o(drained),
      .issueAdd1_o(issueAdd1), .issueAdd2_o(issueAdd2), .issueLoad1_o(issueLoad1),
      .issueLoad2_o(issueLoad2), .issueOp_o(issueOp), .issueVj_o(issueVj), .issueVk_o(issueVk),
      .issueQj_o(issueQj), .issueQk_o(issueQk), .issueA_o(issueA), .stnBusy_o(stnBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t row(input bit valid, input logic [1:0] op, input logic [2:0] rd,
                                input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] imm,
                                input bit cdbV, input logic [2:0] tag, input logic [15:0] cdbD,
                                input bit initWe, input logic [2:0] initA, input logic [15:0] initD,
                                input bit drain);
      vec_t v;
      v = '{default: '0};
      v.valid = valid; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm;
      v.cdbV = cdbV; v.tag = tag; v.cdbD = cdbD;
      v.initWe = initWe; v.initA = initA; v.initD = initD; v.drain = drain;
      v.chkRdy = 1'b1;
      return v;
   endfunction

   function automatic vec_t withExp(input vec_t vin, input bit rdy, input logic [3:0] vec,
                                    input logic [1:0] op, input logic [15:0] vj, input logic [2:0] qj,
                                    input logic [15:0] vk, input logic [2:0] qk, input logic [15:0] a,
                                    input logic [3:0] busy, input bit dr);
      vec_t v;
      v = vin;
      v.expRdy = rdy; v.expVec = vec; v.expOp = op; v.expVj = vj; v.expQj = qj;
      v.expVk = vk; v.expQk = qk; v.expA = a; v.expBusy = busy; v.expDrained = dr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      assertCount++;
      if (act !== expv) begin
         failCount++;
         $display("[TB] FAIL %s (%s): got %0h expected %0h", name, curTag, act, expv);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst = v.rst; instrValid = v.valid; instrOp = v.op; instrRd = v.rd; instrRs = v.rs;
      instrRt = v.rt; instrImm = v.imm; cdbValid = v.cdbV; qiCdb = v.tag; qiCdbData = v.cdbD;
      rfInitWe = v.initWe; rfInitAddr = v.initA; rfInitData = v.initD; drainReq = v.drain;
   endtask

   // One clock: drive, sample ready mid-cycle, then check registered outputs.
   task automatic runCycle(input vec_t v);
      applyStimulus(v);
      @(negedge clk);
      if (v.chkRdy) checkOutput("ready", 32'(instrReady), 32'(v.expRdy));
      @(posedge clk);
      #1;
      checkOutput("issue_vec", 32'({issueLoad2, issueLoad1, issueAdd2, issueAdd1}), 32'(v.expVec));
      checkOutput("issue_op", 32'(issueOp), 32'(v.expOp));
      checkOutput("vj", 32'(issueVj), 32'(v.expVj));
      checkOutput("qj", 32'(issueQj), 32'(v.expQj));
      checkOutput("vk", 32'(issueVk), 32'(v.expVk));
      checkOutput("qk", 32'(issueQk), 32'(v.expQk));
      checkOutput("a", 32'(issueA), 32'(v.expA));
      checkOutput("stn_busy", 32'(stnBusy), 32'(v.expBusy));
      checkOutput("drained", 32'(drained), 32'(v.expDrained));
   endtask

   // Reference model: the architectural rules stated directly on arrays.
   function automatic bit modelReady(input vec_t v);
      int freeCnt;
      if (mMode != 0) return 1'b0;
      if (v.op == 2'd3) return 1'b1;
      if (v.op == 2'd2) freeCnt = (mBusy[2] ? 0 : 1) + (mBusy[3] ? 0 : 1);
      else              freeCnt = (mBusy[0] ? 0 : 1) + (mBusy[1] ? 0 : 1);
      return freeCnt > 0;
   endfunction

   task automatic readSrc(input int r, input bit cdbOn, input int tag, input int data,
                          output int val, output int q);
      if (mQi[r] == 0) begin val = mRf[r]; q = 0; end
      else if (cdbOn && mQi[r] == tag) begin val = data; q = 0; end
      else begin val = 0; q = mQi[r]; end
   endtask

   task automatic modelEdge(inout vec_t v);
      bit cdbOn, acc, wasIdle;
      bit hit[8];
      int newTag, base, val, q;
      v.expVec = '0; v.expOp = '0; v.expVj = '0; v.expVk = '0; v.expQj = '0; v.expQk = '0; v.expA = '0;
      if (v.rst) begin
         for (int r = 0; r < 8; r++) begin mRf[r] = 0; mQi[r] = 0; end
         mBusy = '0; mMode = 0;
      end else begin
         cdbOn = v.cdbV && (v.tag >= 1) && (v.tag <= 4);
         acc = v.valid && modelReady(v);
         newTag = 0;
         if (acc && v.op != 2'd3) begin
            base = (v.op == 2'd2) ? 3 : 1;
            newTag = mBusy[base-1] ? base + 1 : base;
            v.expVec = 4'(1 << (newTag - 1));
            v.expOp = v.op;
            readSrc(int'(v.rs), cdbOn, int'(v.tag), int'(v.cdbD), val, q);
            v.expVj = 16'(val); v.expQj = 3'(q);
            if (v.op == 2'd2) v.expA = v.imm;
            else begin
               readSrc(int'(v.rt), cdbOn, int'(v.tag), int'(v.cdbD), val, q);
               v.expVk = 16'(val); v.expQk = 3'(q);
            end
         end
         wasIdle = (mBusy == 0);
         if (mMode == 0) begin if (v.drain) mMode = 1; end
         else if (!v.drain) mMode = 0;
         else if (mMode == 1 && wasIdle) mMode = 2;
         for (int r = 0; r < 8; r++) begin
            hit[r] = cdbOn && (mQi[r] == int'(v.tag));
            if (hit[r]) begin mRf[r] = int'(v.cdbD); mQi[r] = 0; end
         end
         if (cdbOn) mBusy[int'(v.tag) - 1] = 1'b0;
         if (v.initWe && wasIdle && !hit[v.initA]) begin
            mRf[v.initA] = int'(v.initD); mQi[v.initA] = 0;
         end
         if (newTag != 0) begin
            mQi[v.rd] = newTag;
            mBusy[newTag - 1] = 1'b1;
         end
      end
      v.expBusy = mBusy;
      v.expDrained = (mMode == 2);
   endtask

   initial begin
      vec_t v;
      bit drainLvl;
      applyStimulus(withExp(row(0,0,0,0,0,0, 0,0,0, 0,0,0, 0), 0,0,0,0,0,0,0,0,0,0));
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Directed table: preload, fill/refill ADD stations, LD dependency,
      // CDB forward on issue, drain, reserved op, gated preload.
      v = withExp(row(0,0,0,0,0,0, 0,0,0, 0,0,0, 0), 0,0,0,0,0,0,0,0,0,0);
      v.rst = 1; v.chkRdy = 0; tbl.push_back(v);
      tbl.push_back(withExp(row(0,0,0,0,0,0, 0,0,0, 1,1,5, 0), 1,0,0,0,0,0,0,0,4'b0000,0));
      tbl.push_back(withExp(row(0,0,0,0,0,0, 0,0,0, 1,2,7, 0), 1,0,0,0,0,0,0,0,4'b0000,0));
      tbl.push_back(withExp(row(1,0,3,1,2,0, 0,0,0, 0,0,0, 0), 1,4'b0001,0,5,0,7,0,0,4'b0001,0));
      tbl.push_back(withExp(row(1,0,4,3,1,0, 0,0,0, 0,0,0, 0), 1,4'b0010,0,0,1,5,0,0,4'b0011,0));
      tbl.push_back(withExp(row(1,0,5,1,1,0, 0,0,0, 0,0,0, 0), 0,0,0,0,0,0,0,0,4'b0011,0));
      tbl.push_back(withExp(row(1,0,5,1,1,0, 1,1,12, 0,0,0, 0), 0,0,0,0,0,0,0,0,4'b0010,0));
      tbl.push_back(withExp(row(1,0,5,1,1,0, 0,0,0, 0,0,0, 0), 1,4'b0001,0,5,0,5,0,0,4'b0011,0));
      tbl.push_back(withExp(row(0,0,0,0,0,0, 1,2,20, 0,0,0, 0), 0,0,0,0,0,0,0,0,4'b0001,0));
      tbl.push_back(withExp(row(0,0,0,0,0,0, 1,1,30, 0,0,0, 0), 1,0,0,0,0,0,0,0,4'b0000,0));
      tbl.push_back(withExp(row(1,2,4,1,0,16'h0010, 0,0,0, 0,0,0, 0), 1,4'b0100,2,5,0,0,0,16'h0010,4'b0100,0));
      tbl.push_back(withExp(row(1,0,5,4,1,0, 0,0,0, 0,0,0, 0), 1,4'b0001,0,0,3,5,0,0,4'b0101,0));
      tbl.push_back(withExp(row(0,0,0,0,0,0, 1,3,16'h00AA, 0,0,0, 0), 1,0,0,0,0,0,0,0,4'b0001,0));
      tbl.push_back(withExp(row(1,0,7,4,4,0, 0,0,0, 0,0,0, 0), 1,4'b0010,0,16'h00AA,0,16'h00AA,0,0,4'b0011,0));
      tbl.push_back(withExp(row(0,0,0,0,0,0, 1,1,40, 0,0,0, 0), 0,0,0,0,0,0,0,0,4'b0010,0));
      tbl.push_back(withExp(row(1,1,7,7,0,0, 1,2,9, 0,0,0, 0), 1,4'b0001,1,9,0,0,0,0,4'b0001,0));
      tbl.push_back(withExp(row(1,0,0,7,4,0, 0,0,0, 0,0,0, 0), 1,4'b0010,0,0,1,16'h00AA,0,0,4'b0011,0));
      tbl.push_back(withExp(row(1,2,1,2,0,3, 0,0,0, 0,0,0, 0), 1,4'b0100,2,7,0,0,0,3,4'b0111,0));
      tbl.push_back(withExp(row(0,2,0,0,0,0, 0,0,0, 0,0,0, 1), 1,0,0,0,0,0,0,0,4'b0111,0));
      tbl.push_back(withExp(row(1,2,0,0,0,0, 0,0,0, 0,0,0, 1), 0,0,0,0,0,0,0,0,4'b0111,0));
      tbl.push_back(withExp(row(1,2,0,0,0,0, 1,1,50, 0,0,0, 1), 0,0,0,0,0,0,0,0,4'b0110,0));
      tbl.push_back(withExp(row(0,2,0,0,0,0, 1,2,60, 0,0,0, 1), 0,0,0,0,0,0,0,0,4'b0100,0));
      tbl.push_back(withExp(row(0,2,0,0,0,0, 1,3,70, 0,0,0, 1), 0,0,0,0,0,0,0,0,4'b0000,0));
      tbl.push_back(withExp(row(0,2,0,0,0,0, 0,0,0, 0,0,0, 1), 0,0,0,0,0,0,0,0,4'b0000,1));
      tbl.push_back(withExp(row(0,2,0,0,0,0, 0,0,0, 0,0,0, 1), 0,0,0,0,0,0,0,0,4'b0000,1));
      tbl.push_back(withExp(row(0,2,0,0,0,0, 0,0,0, 0,0,0, 0), 0,0,0,0,0,0,0,0,4'b0000,0));
      tbl.push_back(withExp(row(1,0,2,1,0,0, 0,0,0, 0,0,0, 0), 1,4'b0001,0,70,0,60,0,0,4'b0001,0));
      tbl.push_back(withExp(row(1,3,5,5,5,0, 0,0,0, 0,0,0, 0), 1,0,0,0,0,0,0,0,4'b0001,0));
      tbl.push_back(withExp(row(0,0,0,0,0,0, 0,0,0, 1,5,99, 0), 1,0,0,0,0,0,0,0,4'b0001,0));
      tbl.push_back(withExp(row(1,0,6,5,5,0, 0,0,0, 0,0,0, 0), 1,4'b0010,0,40,0,40,0,0,4'b0011,0));

      foreach (tbl[i]) begin
         curTag = $sformatf("table row %0d", i);
         runCycle(tbl[i]);
      end

      // Reset in the same cycle as an accepted LD with two busy stations,
      // then prove Qi and RF were cleared by reading R2 (was pending) and R7.
      curTag = "reset during issue";
      v = withExp(row(1,2,3,7,0,1, 0,0,0, 0,0,0, 0), 1,0,0,0,0,0,0,0,4'b0000,0);
      v.rst = 1;
      runCycle(v);
      curTag = "after reset";
      runCycle(withExp(row(1,0,4,2,7,0, 0,0,0, 0,0,0, 0), 1,4'b0001,0,0,0,0,0,0,4'b0001,0));

      // Randomized traffic against the reference model.
      drainLvl = 1'b0;
      for (int n = 0; n < 600; n++) begin
         v = row(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 7) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7)),
                 16'($urandom), ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)),
                 16'($urandom), 1'b0);
         if ($urandom_range(0, 24) == 0) drainLvl = !drainLvl;
         v.drain = drainLvl;
         v.rst = (n == 0) || ($urandom_range(0, 149) == 0);
         v.chkRdy = (n != 0);
         v.expRdy = modelReady(v);
         modelEdge(v);
         curTag = $sformatf("random cycle %0d", n);
         runCycle(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
